// File: rtl/riscv_pkg.sv
// Shared RV32 core constants and types used by fetch, decode and hazard logic.
package riscv_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned IMEM_ADDR_W = 10;

    // addi x0,x0,0 -- the canonical bubble word
    localparam logic [XLEN-1:0] NOP_INSTR_VALUE = 32'h0000_0013;

    // Per-cycle fetch behaviour, chosen by priority redirect > stall > run
    typedef enum logic [1:0] {
        FETCH_RUN,
        FETCH_HOLD,
        FETCH_REDIRECT
    } fetch_mode_e;

endpackage

// File: rtl/pc_register.sv
// Program counter: async-reset, enable-gated register with a redirect-target load.
// The stored value is always word aligned; the low two bits never leave zero.
module pc_register
    import riscv_pkg::*;
#(
    parameter logic [IMEM_ADDR_W-1:0] RESET_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   load,
    input  logic [IMEM_ADDR_W-1:0] target,
    output logic [IMEM_ADDR_W-1:0] q
);

    localparam logic [IMEM_ADDR_W-1:0] ALIGN_MASK = {{(IMEM_ADDR_W-2){1'b1}}, 2'b00};

    // Load wins over increment; increment wraps modulo 2^IMEM_ADDR_W
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VALUE & ALIGN_MASK;
        end else if (load) begin
            q <= target & ALIGN_MASK;
        end else if (en) begin
            q <= q + IMEM_ADDR_W'(4);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC drives memory combinationally, the returned word
// is captured in the IF/ID register one edge later. Redirect inserts a bubble.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [IMEM_ADDR_W-1:0] RESET_PC  = 10'h000,
    parameter logic [XLEN-1:0]        NOP_INSTR = NOP_INSTR_VALUE
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [IMEM_ADDR_W-1:0] address,
    input  logic [XLEN-1:0]        instruction,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [IMEM_ADDR_W-1:0] redirect_target,
    output logic [IMEM_ADDR_W-1:0] if_id_pc,
    output logic [XLEN-1:0]        if_id_instruction,
    output logic                   if_id_valid,
    output logic [XLEN-1:0]        fetch_count
);

    localparam logic [IMEM_ADDR_W-1:0] ALIGN_MASK = {{(IMEM_ADDR_W-2){1'b1}}, 2'b00};

    fetch_mode_e            mode;
    logic                   pc_en;
    logic                   pc_load;
    logic [IMEM_ADDR_W-1:0] pc;

    // Select this cycle's mode: redirect beats stall, otherwise run
    always_comb begin
        mode = FETCH_RUN;
        if (redirect) begin
            mode = FETCH_REDIRECT;
        end else if (stall) begin
            mode = FETCH_HOLD;
        end
        pc_en   = (mode == FETCH_RUN);
        pc_load = (mode == FETCH_REDIRECT);
    end

    pc_register #(
        .RESET_VALUE(RESET_PC)
    ) u_pc (
        .clk    (clk),
        .reset  (reset),
        .en     (pc_en),
        .load   (pc_load),
        .target (redirect_target),
        .q      (pc)
    );

    // Zero-latency path from PC to instruction memory
    assign address = pc;

    // IF/ID register: capture on run, bubble on redirect, hold on stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_pc          <= RESET_PC & ALIGN_MASK;
            if_id_instruction <= NOP_INSTR;
            if_id_valid       <= 1'b0;
        end else begin
            case (mode)
                FETCH_RUN: begin
                    if_id_pc          <= pc;
                    if_id_instruction <= instruction;
                    if_id_valid       <= 1'b1;
                end
                FETCH_REDIRECT: begin
                    if_id_pc          <= pc;
                    if_id_instruction <= NOP_INSTR;
                    if_id_valid       <= 1'b0;
                end
                default: begin
                    if_id_pc          <= if_id_pc;
                    if_id_instruction <= if_id_instruction;
                    if_id_valid       <= if_id_valid;
                end
            endcase
        end
    end

    // Count instructions loaded valid into IF/ID
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (mode == FETCH_RUN) begin
            fetch_count <= fetch_count + XLEN'(1);
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by a
// randomized run, all compared against a cycle-level behavioural model.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic [9:0]  address;
    logic [31:0] instruction;
    logic        stall;
    logic        redirect;
    logic [9:0]  redirect_target;
    logic [9:0]  if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    localparam logic [9:0]  RST_PC = 10'h000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic [31:0] mem [256];

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int unsigned m_pc;
    int unsigned m_if_pc;
    logic [31:0] m_if_instr;
    logic        m_if_valid;
    int unsigned m_count;

    instruction_fetch #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .address           (address),
        .instruction       (instruction),
        .stall             (stall),
        .redirect          (redirect),
        .redirect_target   (redirect_target),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid),
        .fetch_count       (fetch_count)
    );

    assign instruction = mem[address[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = RST_PC;
        m_if_pc    = RST_PC;
        m_if_instr = NOP;
        m_if_valid = 1'b0;
        m_count    = 0;
    endtask

    // One clock edge of the architectural behaviour
    task automatic model_step(input logic red, input logic stl, input logic [9:0] tgt);
        if (red) begin
            m_if_pc    = m_pc;
            m_if_instr = NOP;
            m_if_valid = 1'b0;
            m_pc       = (int'(tgt) / 4) * 4;
        end else if (!stl) begin
            m_if_pc    = m_pc;
            m_if_instr = mem[m_pc / 4];
            m_if_valid = 1'b1;
            m_pc       = (m_pc + 4) % 1024;
            m_count    = m_count + 1;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".address"}, 32'(address), 32'(m_pc));
        check({tag, ".align"}, 32'(address[1:0]), 32'd0);
        check({tag, ".if_id_pc"}, 32'(if_id_pc), 32'(m_if_pc));
        check({tag, ".if_id_instr"}, if_id_instruction, m_if_instr);
        check({tag, ".if_id_valid"}, 32'(if_id_valid), 32'(m_if_valid));
        check({tag, ".fetch_count"}, fetch_count, m_count);
    endtask

    // Apply inputs, take one edge, advance model, compare #1 after the edge
    task automatic cycle(input logic red, input logic stl, input logic [9:0] tgt, input string tag);
        redirect        = red;
        stall           = stl;
        redirect_target = tgt;
        @(posedge clk);
        model_step(red, stl, tgt);
        #1;
        check_model(tag);
    endtask

    // Reset pulse placed between clock edges; outputs checked while reset is high
    task automatic mid_cycle_reset(input string tag);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check_model(tag);
        check({tag, ".rst_addr"}, 32'(address), 32'(RST_PC));
        #1;
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        mem[3] = 32'h44;

        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_target = '0;
        model_reset();
        #2;
        check_model("reset");
        #5;
        reset = 1'b0;

        // free-running fetch from address 0
        cycle(1'b0, 1'b0, '0, "run1");
        check("run1.instr", if_id_instruction, 32'h11);
        cycle(1'b0, 1'b0, '0, "run2");
        check("run2.instr", if_id_instruction, 32'h22);
        check("run2.addr", 32'(address), 32'd8);

        // stall two cycles at pc=8
        cycle(1'b0, 1'b1, '0, "stall1");
        cycle(1'b0, 1'b1, '0, "stall2");
        check("stall2.addr", 32'(address), 32'd8);
        check("stall2.if_id_pc", 32'(if_id_pc), 32'd4);
        check("stall2.instr", if_id_instruction, 32'h22);
        check("stall2.count", fetch_count, 32'd2);

        // resume at 8
        cycle(1'b0, 1'b0, '0, "resume");
        check("resume.if_id_pc", 32'(if_id_pc), 32'd8);
        check("resume.instr", if_id_instruction, 32'h33);
        check("resume.count", fetch_count, 32'd3);

        // redirect at pc=12 with unaligned target
        cycle(1'b1, 1'b0, 10'h0A7, "redir");
        check("redir.addr", 32'(address), 32'h0A4);
        check("redir.instr", if_id_instruction, 32'h13);
        check("redir.valid", 32'(if_id_valid), 32'd0);
        check("redir.if_id_pc", 32'(if_id_pc), 32'd12);
        check("redir.count", fetch_count, 32'd3);

        // redirect and stall together: redirect wins
        cycle(1'b1, 1'b1, 10'h040, "redir_stall");
        check("redir_stall.addr", 32'(address), 32'h040);
        check("redir_stall.valid", 32'(if_id_valid), 32'd0);

        // wrap at top of address space
        cycle(1'b1, 1'b0, 10'h3FC, "to_top");
        cycle(1'b0, 1'b0, '0, "wrap");
        check("wrap.addr", 32'(address), 32'h000);
        check("wrap.if_id_pc", 32'(if_id_pc), 32'h3FC);

        // reset between edges during a stall
        cycle(1'b0, 1'b0, '0, "pre_stall");
        cycle(1'b0, 1'b1, '0, "rst_stall");
        mid_cycle_reset("rst_mid_stall");
        cycle(1'b0, 1'b0, '0, "post_rst");
        check("post_rst.if_id_pc", 32'(if_id_pc), 32'(RST_PC));
        check("post_rst.instr", if_id_instruction, 32'h11);

        // reset during a pending redirect discards it
        redirect = 1'b1;
        redirect_target = 10'h200;
        mid_cycle_reset("rst_mid_redir");
        cycle(1'b0, 1'b0, '0, "post_rst2");

        // randomized run
        for (int n = 0; n < 400; n++) begin
            logic       r;
            logic       s;
            logic [9:0] t;
            r = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 3) == 0);
            t = 10'($urandom);
            cycle(r, s, t, "rand");
            if ($urandom_range(0, 49) == 0) mid_cycle_reset("rand_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
